// File: rtl/ap_ctrl_start_sequencer.sv
// ap_ctrl_hs start sequencer: issues NUM_TRANS start handshakes, measures the
// start-to-done latency of each transaction and raises finish at the end or on timeout.
module ap_ctrl_start_sequencer #(
    parameter int NUM_TRANS = 8,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 1000,
    parameter int START_GAP = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic             ap_start,
    output logic             ap_continue,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             finish,
    output logic [CNT_W-1:0] trans_count,
    output logic [CNT_W-1:0] latency,
    output logic             latency_valid,
    output logic             timeout_err
);
    typedef enum logic [2:0] {IDLE, START, WAIT_DONE, GAP, FINISH, ERROR} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [31:0]      GAP_CYC = START_GAP;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    state_t           state_q, state_d;
    logic             ap_start_q, ap_start_d;
    logic             finish_q, finish_d;
    logic             timeout_err_q, timeout_err_d;
    logic             lat_valid_q, lat_valid_d;
    logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [CNT_W-1:0] trans_cnt_q, trans_cnt_d;
    logic [CNT_W-1:0] latency_q, latency_d;
    logic [31:0]      gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] trans_next;

    always_comb begin
        state_d       = state_q;
        ap_start_d    = ap_start_q;
        finish_d      = finish_q;
        timeout_err_d = timeout_err_q;
        lat_valid_d   = 1'b0;
        lat_cnt_d     = lat_cnt_q;
        trans_cnt_d   = trans_cnt_q;
        latency_d     = latency_q;
        gap_cnt_d     = gap_cnt_q;
        trans_next    = sat_inc(trans_cnt_q);
        case (state_q)
            IDLE: begin
                if (NUM_TRANS == 0) begin
                    state_d  = FINISH;
                    finish_d = 1'b1;
                end else if (enable) begin
                    state_d    = START;
                    ap_start_d = 1'b1;
                    lat_cnt_d  = '0;
                end
            end
            START, WAIT_DONE: begin
                // done wins over timeout, so a done exactly TIMEOUT cycles after start still completes
                if (ap_done) begin
                    ap_start_d  = 1'b0;
                    latency_d   = lat_cnt_q;
                    lat_valid_d = 1'b1;
                    trans_cnt_d = trans_next;
                    if (64'(trans_next) == 64'(NUM_TRANS)) begin
                        state_d  = FINISH;
                        finish_d = 1'b1;
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = '0;
                    end
                end else if (64'(lat_cnt_q) >= 64'(TIMEOUT)) begin
                    state_d       = ERROR;
                    ap_start_d    = 1'b0;
                    finish_d      = 1'b1;
                    timeout_err_d = 1'b1;
                end else begin
                    lat_cnt_d = sat_inc(lat_cnt_q);
                    if (state_q == START && ap_ready) begin
                        state_d    = WAIT_DONE;
                        ap_start_d = 1'b0;
                    end
                end
            end
            GAP: begin
                // the completion cycle itself is GAP cycle 0, so ap_start stays low START_GAP+1 cycles
                if (gap_cnt_q < GAP_CYC) begin
                    gap_cnt_d = gap_cnt_q + 32'd1;
                end else if (enable) begin
                    state_d    = START;
                    ap_start_d = 1'b1;
                    lat_cnt_d  = '0;
                end else if (GAP_CYC == 32'd0) begin
                    state_d = IDLE;
                end
            end
            FINISH, ERROR: ;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            ap_start_q    <= 1'b0;
            finish_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            lat_valid_q   <= 1'b0;
            lat_cnt_q     <= '0;
            trans_cnt_q   <= '0;
            latency_q     <= '0;
            gap_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            ap_start_q    <= ap_start_d;
            finish_q      <= finish_d;
            timeout_err_q <= timeout_err_d;
            lat_valid_q   <= lat_valid_d;
            lat_cnt_q     <= lat_cnt_d;
            trans_cnt_q   <= trans_cnt_d;
            latency_q     <= latency_d;
            gap_cnt_q     <= gap_cnt_d;
        end
    end

    assign ap_start      = ap_start_q;
    assign ap_continue   = 1'b1;
    assign finish        = finish_q;
    assign timeout_err   = timeout_err_q;
    assign latency_valid = lat_valid_q;
    assign trans_count   = trans_cnt_q;
    assign latency       = latency_q;

endmodule

// File: tb/tb_ap_ctrl_start_sequencer.sv
// Bench for ap_ctrl_start_sequencer: three instances (default, START_GAP=2, NUM_TRANS=0)
// driven by a modelled ap_ctrl_hs DUT with fixed, combinational and random response times.
module tb_ap_ctrl_start_sequencer;
    localparam int CNT_W = 16;
    localparam int N     = 8;
    localparam int TMO   = 1000;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic rst0 = 1'b1, en0 = 1'b0, rdy0 = 1'b0, dn0 = 1'b0;
    logic rst1 = 1'b1, en1 = 1'b0, rdy1 = 1'b0, dn1 = 1'b0;
    logic rst2 = 1'b1, en2 = 1'b0, rdy2 = 1'b0, dn2 = 1'b0;
    logic st0, cont0, fin0, lv0, terr0;
    logic st1, cont1, fin1, lv1, terr1;
    logic st2, cont2, fin2, lv2, terr2;
    logic [CNT_W-1:0] cnt0, lat0, cnt1, lat1, cnt2, lat2;

    ap_ctrl_start_sequencer #(.NUM_TRANS(N), .CNT_W(CNT_W), .TIMEOUT(TMO), .START_GAP(0)) u_dut0 (
        .clock(clock), .reset(rst0), .enable(en0), .ap_start(st0), .ap_continue(cont0),
        .ap_ready(rdy0), .ap_done(dn0), .finish(fin0), .trans_count(cnt0), .latency(lat0),
        .latency_valid(lv0), .timeout_err(terr0));

    ap_ctrl_start_sequencer #(.NUM_TRANS(N), .CNT_W(CNT_W), .TIMEOUT(TMO), .START_GAP(2)) u_dut1 (
        .clock(clock), .reset(rst1), .enable(en1), .ap_start(st1), .ap_continue(cont1),
        .ap_ready(rdy1), .ap_done(dn1), .finish(fin1), .trans_count(cnt1), .latency(lat1),
        .latency_valid(lv1), .timeout_err(terr1));

    ap_ctrl_start_sequencer #(.NUM_TRANS(0), .CNT_W(CNT_W), .TIMEOUT(TMO), .START_GAP(0)) u_dut2 (
        .clock(clock), .reset(rst2), .enable(en2), .ap_start(st2), .ap_continue(cont2),
        .ap_ready(rdy2), .ap_done(dn2), .finish(fin2), .trans_count(cnt2), .latency(lat2),
        .latency_valid(lv2), .timeout_err(terr2));

    task automatic test_reset();
        @(negedge clock);
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        en0 = 1'b1; en1 = 1'b1; en2 = 1'b1;
        @(negedge clock);
        total++;
        if ({st0, fin0, lv0, terr0, st1, fin1, lv1, terr1, st2, fin2, lv2, terr2} !== 12'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=0", {st0, fin0, lv0, terr0, st1, fin1, lv1, terr1, st2, fin2, lv2, terr2});
        end
        total++;
        if ({cnt0, lat0, cnt1, lat1, cnt2, lat2} !== 96'h0) begin
            bad++;
            $display("FAIL reset_counters got=%h want=0", {cnt0, lat0, cnt1, lat1, cnt2, lat2});
        end
        total++;
        if ({cont0, cont1, cont2} !== 3'b111) begin
            bad++;
            $display("FAIL reset_ap_continue got=%b want=111", {cont0, cont1, cont2});
        end
    endtask

    // mode 0: ready+done 3 cycles after start; mode 1: ready=done=ap_start; mode 2: random
    task automatic test_handshake(input int mode);
        int  start_c = 0, done_c = -10, d_lat = 0, r_lat = 0, lat_done = 0;
        int  n_iss = 0, earliest = 0, pend_k = -1, exp_cnt = 0, exp_lat = 0, fin_k = -1;
        bit  busy = 1'b0, exp_st = 1'b0, drop_st = 1'b0, fin_exp = 1'b0;
        @(negedge clock);
        rst0 = 1'b1; en0 = 1'b0; rdy0 = 1'b0; dn0 = 1'b0;
        @(negedge clock);
        rst0 = 1'b0;
        for (int k = 0; k < 800; k++) begin
            if (k > 0) @(negedge clock);
            if (drop_st) begin
                exp_st  = 1'b0;
                drop_st = 1'b0;
            end
            if (k == done_c + 1) begin
                exp_cnt++;
                exp_lat = lat_done;
                if (exp_cnt == N) fin_exp = 1'b1;
            end
            if (k == pend_k) begin
                busy = 1'b1; exp_st = 1'b1; start_c = k; n_iss++;
                if (mode == 0) begin
                    d_lat = 3; r_lat = 3;
                end else if (mode == 1) begin
                    d_lat = 0; r_lat = 0;
                end else begin
                    d_lat = int'($urandom_range(0, 7));
                    if ($urandom_range(0, 3) == 0) r_lat = -1;
                    else r_lat = int'($urandom_range(0, d_lat));
                end
            end
            total++;
            if (st0 !== exp_st) begin
                bad++; $display("FAIL hs%0d_ap_start k=%0d got=%b want=%b", mode, k, st0, exp_st);
            end
            total++;
            if (lv0 !== (k == done_c + 1)) begin
                bad++; $display("FAIL hs%0d_latency_valid k=%0d got=%b want=%b", mode, k, lv0, (k == done_c + 1));
            end
            total++;
            if (cnt0 !== CNT_W'(exp_cnt)) begin
                bad++; $display("FAIL hs%0d_trans_count k=%0d got=%0d want=%0d", mode, k, cnt0, exp_cnt);
            end
            total++;
            if (lat0 !== CNT_W'(exp_lat)) begin
                bad++; $display("FAIL hs%0d_latency k=%0d got=%0d want=%0d", mode, k, lat0, exp_lat);
            end
            total++;
            if ({fin0, terr0} !== {fin_exp, 1'b0}) begin
                bad++; $display("FAIL hs%0d_finish k=%0d got=%b want=%b", mode, k, {fin0, terr0}, {fin_exp, 1'b0});
            end
            if (fin_exp && fin_k < 0) fin_k = k;
            if (fin_k >= 0 && k >= fin_k + 6) break;
            rdy0 = 1'b0; dn0 = 1'b0;
            en0  = (mode == 2) ? ($urandom_range(0, 4) != 0) : 1'b1;
            if (fin_exp) begin
                rdy0 = 1'($urandom_range(0, 1));
                dn0  = 1'($urandom_range(0, 1));
            end else if (mode == 1) begin
                rdy0 = st0; dn0 = st0;
            end else if (busy) begin
                rdy0 = (r_lat >= 0) && (k == start_c + r_lat);
                dn0  = (k == start_c + d_lat);
            end
            if (busy && (rdy0 || dn0)) drop_st = 1'b1;
            if (busy && dn0) begin
                busy = 1'b0; done_c = k; lat_done = k - start_c; earliest = k + 1;
            end
            if (!busy && pend_k <= k && n_iss < N && k >= earliest && en0) pend_k = k + 1;
        end
        total++;
        if (fin_k < 0) begin
            bad++; $display("FAIL hs%0d_bound got=%0d want=%0d transactions", mode, exp_cnt, N);
        end
    endtask

    task automatic test_timeout();
        int t = -1;
        @(negedge clock);
        rst0 = 1'b1; en0 = 1'b0; rdy0 = 1'b0; dn0 = 1'b0;
        @(negedge clock);
        rst0 = 1'b0; en0 = 1'b1;
        for (int k = 0; k < TMO + 30; k++) begin
            if (k > 0) @(negedge clock);
            if (t < 0 && st0 === 1'b1) t = k;
            if (t >= 0 && k == t + TMO) begin
                total++;
                if ({st0, terr0, fin0} !== 3'b100) begin
                    bad++; $display("FAIL timeout_before got=%b want=100", {st0, terr0, fin0});
                end
            end
            if (t >= 0 && k == t + TMO + 1) begin
                total++;
                if ({st0, terr0, fin0} !== 3'b011) begin
                    bad++; $display("FAIL timeout_edge got=%b want=011", {st0, terr0, fin0});
                end
            end
            if (t >= 0 && k == t + TMO + 10) begin
                total++;
                if ({st0, terr0, fin0, lv0, cnt0} !== {4'b0110, 16'd0}) begin
                    bad++; $display("FAIL timeout_sticky got=%h want=%h", {st0, terr0, fin0, lv0, cnt0}, {4'b0110, 16'd0});
                end
            end
            rdy0 = 1'b0;
            dn0  = (t >= 0) && (k > t + TMO + 1);
        end
        total++;
        if (t < 0) begin
            bad++; $display("FAIL timeout_no_start got=0 want=1");
        end
        dn0 = 1'b0;
    endtask

    task automatic test_gap_enable();
        int  t = -1, d = -1, ncmp = 0, exp_start = 0, off_k = -1;
        bit  prev_st = 1'b0, fin_seen = 1'b0;
        @(negedge clock);
        rst1 = 1'b1; en1 = 1'b0; rdy1 = 1'b0; dn1 = 1'b0;
        @(negedge clock);
        rst1 = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (k > 0) @(negedge clock);
            if (st1 && !prev_st) begin
                if (ncmp > 0) begin
                    total++;
                    if (k != exp_start) begin
                        bad++; $display("FAIL gap_start_cycle n=%0d got=%0d want=%0d", ncmp, k, exp_start);
                    end
                end
                t = k;
            end
            prev_st = st1;
            if (off_k >= 0 && k >= off_k && k <= off_k + 5) begin
                total++;
                if (st1 !== 1'b0) begin
                    bad++; $display("FAIL gap_enable_low k=%0d got=%b want=0", k, st1);
                end
            end
            if (ncmp == N && k == d + 1) begin
                total++;
                if ({fin1, cnt1, lat1} !== {1'b1, 16'd8, 16'd1}) begin
                    bad++; $display("FAIL gap_finish got=%h want=%h", {fin1, cnt1, lat1}, {1'b1, 16'd8, 16'd1});
                end
                fin_seen = 1'b1;
            end
            if (fin_seen && k >= d + 4) break;
            en1  = !(off_k >= 0 && k >= off_k && k < off_k + 5);
            rdy1 = (t >= 0) && (k == t + 1);
            dn1  = rdy1;
            if (dn1) begin
                ncmp++; d = k; t = -1;
                if (ncmp == 3) begin
                    off_k = k + 1;
                    exp_start = k + 7;
                end else begin
                    exp_start = k + 4;
                end
            end
        end
        total++;
        if (!fin_seen) begin
            bad++; $display("FAIL gap_bound got=%0d want=%0d transactions", ncmp, N);
        end
        en1 = 1'b0; rdy1 = 1'b0; dn1 = 1'b0;
    endtask

    task automatic test_reset_mid();
        int t = -1, ncmp = 0;
        bit hit = 1'b0;
        @(negedge clock);
        rst0 = 1'b1; en0 = 1'b0; rdy0 = 1'b0; dn0 = 1'b0;
        @(negedge clock);
        rst0 = 1'b0; en0 = 1'b1;
        for (int k = 0; k < 200 && !hit; k++) begin
            if (k > 0) @(negedge clock);
            if (st0 && t < 0) t = k;
            rdy0 = 1'b0; dn0 = 1'b0;
            if (t >= 0) begin
                if (k == t + 1) rdy0 = 1'b1;
                if (ncmp < 3 && k == t + 4) begin
                    dn0 = 1'b1; ncmp++; t = -1;
                end else if (ncmp == 3 && k == t + 3) begin
                    hit = 1'b1;
                end
            end
        end
        total++;
        if ({hit, cnt0, lat0} !== {1'b1, 16'd3, 16'd4}) begin
            bad++; $display("FAIL midreset_setup got=%h want=%h", {hit, cnt0, lat0}, {1'b1, 16'd3, 16'd4});
        end
        #2 rst0 = 1'b1;
        #1;
        total++;
        if ({st0, fin0, lv0, terr0, cnt0, lat0} !== 36'h0) begin
            bad++; $display("FAIL midreset_async got=%h want=0", {st0, fin0, lv0, terr0, cnt0, lat0});
        end
    endtask

    task automatic test_zero_trans();
        @(negedge clock);
        rst2 = 1'b1; en2 = 1'b1;
        @(negedge clock);
        rst2 = 1'b0;
        total++;
        if (fin2 !== 1'b0) begin
            bad++; $display("FAIL zero_finish_early got=%b want=0", fin2);
        end
        @(negedge clock);
        total++;
        if (fin2 !== 1'b1) begin
            bad++; $display("FAIL zero_finish got=%b want=1", fin2);
        end
        for (int k = 0; k < 10; k++) begin
            rdy2 = 1'($urandom_range(0, 1));
            dn2  = 1'($urandom_range(0, 1));
            @(negedge clock);
            total++;
            if ({st2, fin2, cnt2, lv2, terr2} !== {2'b01, 16'd0, 2'b00}) begin
                bad++; $display("FAIL zero_idle k=%0d got=%h want=%h", k, {st2, fin2, cnt2, lv2, terr2}, {2'b01, 16'd0, 2'b00});
            end
        end
    endtask

    initial begin
        test_reset();
        test_handshake(0);
        test_handshake(1);
        test_timeout();
        test_gap_enable();
        test_reset_mid();
        test_handshake(0);
        for (int r = 0; r < 4; r++) test_handshake(2);
        test_zero_trans();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
